// File: rtl/lc3_execute.sv
// rtl/lc3_execute.sv - LC3 execute stage: ALU, address adder, operand bypass and stage registers
//
// Purpose: computes the ADD/AND/NOT result and the effective/branch address for the
// instruction presented by decode, and registers them with the forwarded control fields.
// Ports:
//   clock, reset            rising-edge clock, asynchronous active-high reset
//   enable_execute          1 = capture this cycle, 0 = hold every register
//   E_control               {alu_op[5:4], pcselect1[3:2], pcselect2[1], op2select[0]}
//   IR, npc_in              instruction and next-PC from decode
//   Mem_control_in, W_control_in   control fields passed through to later stages
//   VSR1, VSR2              register-file operands
//   bypass_alu_1/2, bypass_mem_1/2, Mem_Bypass_Val   operand forwarding controls/data
//   sr1, sr2                combinational source-register indices for the register file
//   aluout, pcout, dr, NZP, M_Data, W_control_out, Mem_control_out, IR_Exec   registered results
module lc3_execute #(
    parameter int DW = 16
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          enable_execute,
    input  logic [5:0]    E_control,
    input  logic [DW-1:0] IR,
    input  logic [DW-1:0] npc_in,
    input  logic          Mem_control_in,
    input  logic [1:0]    W_control_in,
    input  logic [DW-1:0] VSR1,
    input  logic [DW-1:0] VSR2,
    input  logic          bypass_alu_1,
    input  logic          bypass_alu_2,
    input  logic          bypass_mem_1,
    input  logic          bypass_mem_2,
    input  logic [DW-1:0] Mem_Bypass_Val,
    output logic [2:0]    sr1,
    output logic [2:0]    sr2,
    output logic [DW-1:0] aluout,
    output logic [DW-1:0] pcout,
    output logic [2:0]    dr,
    output logic [2:0]    NZP,
    output logic [DW-1:0] M_Data,
    output logic [1:0]    W_control_out,
    output logic          Mem_control_out,
    output logic [DW-1:0] IR_Exec
);

    localparam logic [3:0] OP_BR  = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_LD  = 4'b0010;
    localparam logic [3:0] OP_ST  = 4'b0011;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_LDR = 4'b0110;
    localparam logic [3:0] OP_STR = 4'b0111;
    localparam logic [3:0] OP_NOT = 4'b1001;
    localparam logic [3:0] OP_LDI = 4'b1010;
    localparam logic [3:0] OP_STI = 4'b1011;
    localparam logic [3:0] OP_JMP = 4'b1100;
    localparam logic [3:0] OP_LEA = 4'b1110;

    logic [DW-1:0] aluout_q, aluout_d;
    logic [DW-1:0] pcout_q, pcout_d;
    logic [2:0]    dr_q, dr_d;
    logic [2:0]    nzp_q, nzp_d;
    logic [DW-1:0] mdata_q, mdata_d;
    logic [1:0]    wctl_q, wctl_d;
    logic          mctl_q, mctl_d;
    logic [DW-1:0] ir_q, ir_d;

    logic [3:0]    opcode;
    logic [1:0]    alu_op;
    logic [1:0]    pcselect1;
    logic          pcselect2;
    logic          op2select;
    logic [DW-1:0] op1, r2, op2, alu_res, base, offset, addr;

    assign opcode    = IR[15:12];
    assign alu_op    = E_control[5:4];
    assign pcselect1 = E_control[3:2];
    assign pcselect2 = E_control[1];
    assign op2select = E_control[0];

    // Stores read their data register from the dr field, so sr2 moves there for them.
    assign sr1 = IR[8:6];
    assign sr2 = (opcode == OP_ST || opcode == OP_STR || opcode == OP_STI) ? IR[11:9] : IR[2:0];

    always_comb begin
        // ALU forwarding wins over memory forwarding: it holds the younger result.
        op1 = bypass_alu_1 ? aluout_q : (bypass_mem_1 ? Mem_Bypass_Val : VSR1);
        r2  = bypass_alu_2 ? aluout_q : (bypass_mem_2 ? Mem_Bypass_Val : VSR2);
        op2 = op2select ? r2 : {{(DW-5){IR[4]}}, IR[4:0]};

        case (alu_op)
            2'b00:   alu_res = op1 + op2;
            2'b01:   alu_res = op1 & op2;
            2'b10:   alu_res = ~op1;
            default: alu_res = '0;
        endcase

        base = pcselect2 ? npc_in : op1;
        case (pcselect1)
            2'b00:   offset = {{(DW-11){IR[10]}}, IR[10:0]};
            2'b01:   offset = {{(DW-9){IR[8]}}, IR[8:0]};
            2'b10:   offset = {{(DW-6){IR[5]}}, IR[5:0]};
            default: offset = '0;
        endcase
        addr = base + offset;
    end

    always_comb begin
        aluout_d = aluout_q;
        pcout_d  = pcout_q;
        dr_d     = dr_q;
        nzp_d    = nzp_q;
        mdata_d  = mdata_q;
        wctl_d   = wctl_q;
        mctl_d   = mctl_q;
        ir_d     = ir_q;
        if (enable_execute) begin
            pcout_d  = addr;
            aluout_d = (opcode == OP_ADD || opcode == OP_AND || opcode == OP_NOT) ? alu_res : addr;
            case (opcode)
                OP_ADD, OP_AND, OP_NOT, OP_LD, OP_LDR, OP_LDI, OP_LEA: dr_d = IR[11:9];
                default: dr_d = 3'b000;
            endcase
            case (opcode)
                OP_BR:   nzp_d = IR[11:9];
                OP_JMP:  nzp_d = 3'b111;
                default: nzp_d = 3'b000;
            endcase
            mdata_d  = r2;
            wctl_d   = W_control_in;
            mctl_d   = Mem_control_in;
            ir_d     = IR;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            aluout_q <= '0;
            pcout_q  <= '0;
            dr_q     <= '0;
            nzp_q    <= '0;
            mdata_q  <= '0;
            wctl_q   <= '0;
            mctl_q   <= 1'b0;
            ir_q     <= '0;
        end else begin
            aluout_q <= aluout_d;
            pcout_q  <= pcout_d;
            dr_q     <= dr_d;
            nzp_q    <= nzp_d;
            mdata_q  <= mdata_d;
            wctl_q   <= wctl_d;
            mctl_q   <= mctl_d;
            ir_q     <= ir_d;
        end
    end

    assign aluout          = aluout_q;
    assign pcout           = pcout_q;
    assign dr              = dr_q;
    assign NZP             = nzp_q;
    assign M_Data          = mdata_q;
    assign W_control_out   = wctl_q;
    assign Mem_control_out = mctl_q;
    assign IR_Exec         = ir_q;

endmodule

// File: tb/tb_lc3_execute.sv
// tb/tb_lc3_execute.sv - self-checking bench for lc3_execute
module tb_lc3_execute;

    typedef struct packed {
        logic [15:0] alu;
        logic [15:0] pc;
        logic [2:0]  dr;
        logic [2:0]  nzp;
        logic [15:0] md;
        logic [1:0]  wc;
        logic        mc;
        logic [15:0] ir;
    } res_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enable_execute = 1'b0;
    logic [5:0]  E_control = '0;
    logic [15:0] IR = '0;
    logic [15:0] npc_in = '0;
    logic        Mem_control_in = 1'b0;
    logic [1:0]  W_control_in = '0;
    logic [15:0] VSR1 = '0;
    logic [15:0] VSR2 = '0;
    logic        bypass_alu_1 = 1'b0;
    logic        bypass_alu_2 = 1'b0;
    logic        bypass_mem_1 = 1'b0;
    logic        bypass_mem_2 = 1'b0;
    logic [15:0] Mem_Bypass_Val = '0;
    logic [2:0]  sr1, sr2, dr, NZP;
    logic [15:0] aluout, pcout, M_Data, IR_Exec;
    logic [1:0]  W_control_out;
    logic        Mem_control_out;

    int   tests_run = 0;
    int   tests_failed = 0;
    res_t sb[$];
    res_t last_exp = '0;

    lc3_execute #(.DW(16)) dut (
        .clock(clock), .reset(reset), .enable_execute(enable_execute),
        .E_control(E_control), .IR(IR), .npc_in(npc_in),
        .Mem_control_in(Mem_control_in), .W_control_in(W_control_in),
        .VSR1(VSR1), .VSR2(VSR2),
        .bypass_alu_1(bypass_alu_1), .bypass_alu_2(bypass_alu_2),
        .bypass_mem_1(bypass_mem_1), .bypass_mem_2(bypass_mem_2),
        .Mem_Bypass_Val(Mem_Bypass_Val),
        .sr1(sr1), .sr2(sr2), .aluout(aluout), .pcout(pcout), .dr(dr), .NZP(NZP),
        .M_Data(M_Data), .W_control_out(W_control_out),
        .Mem_control_out(Mem_control_out), .IR_Exec(IR_Exec)
    );

    always #5 clock = ~clock;

    function automatic res_t observe();
        res_t r;
        r.alu = aluout; r.pc = pcout; r.dr = dr; r.nzp = NZP; r.md = M_Data;
        r.wc = W_control_out; r.mc = Mem_control_out; r.ir = IR_Exec;
        return r;
    endfunction

    // Drives one enabled instruction and queues what the stage must register for it.
    task automatic apply(input logic [15:0] ir_v, input logic [5:0] ec, input logic [15:0] npc,
                         input logic [15:0] v1, input logic [15:0] v2,
                         input logic [3:0] byp, input logic [15:0] mbv,
                         input logic [1:0] wc, input logic mc, input res_t exp);
        enable_execute = 1'b1;
        IR = ir_v; E_control = ec; npc_in = npc; VSR1 = v1; VSR2 = v2;
        {bypass_alu_1, bypass_mem_1, bypass_alu_2, bypass_mem_2} = byp;
        Mem_Bypass_Val = mbv; W_control_in = wc; Mem_control_in = mc;
        sb.push_back(exp);
    endtask

    task automatic test_reset();
        res_t got;
        #2;
        got = observe();
        tests_run++;
        if (got !== res_t'(0)) begin
            tests_failed++;
            $display("FAIL reset_state got=%h exp=0", got);
        end
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_alu();
        res_t exp, got;
        res_t cases[4];
        logic [15:0] irs[4];
        logic [5:0]  ecs[4];
        logic [15:0] v1s[4];
        logic [15:0] v2s[4];
        irs = '{16'h1642, 16'h553F, 16'h967F, 16'h1642};
        ecs = '{6'b000001, 6'b010000, 6'b100000, 6'b110001};
        v1s = '{16'h0005, 16'hA5A5, 16'h00FF, 16'h0005};
        v2s = '{16'h0007, 16'h1111, 16'h2222, 16'h0007};
        cases[0] = '{16'h000C, 16'hFE47, 3'd3, 3'd0, 16'h0007, 2'b01, 1'b0, 16'h1642};
        cases[1] = '{16'hA5A5, 16'hA2E4, 3'd2, 3'd0, 16'h1111, 2'b01, 1'b0, 16'h553F};
        cases[2] = '{16'hFF00, 16'hFF7E, 3'd3, 3'd0, 16'h2222, 2'b01, 1'b0, 16'h967F};
        cases[3] = '{16'h0000, 16'hFE47, 3'd3, 3'd0, 16'h0007, 2'b01, 1'b0, 16'h1642};
        for (int i = 0; i < 4; i++) begin
            apply(irs[i], ecs[i], 16'h0000, v1s[i], v2s[i], 4'b0000, 16'h0, 2'b01, 1'b0, cases[i]);
            if (i == 0) begin
                #1;
                tests_run++;
                if (sr1 !== 3'd1 || sr2 !== 3'd2) begin
                    tests_failed++;
                    $display("FAIL add_srcs got sr1=%0d sr2=%0d exp sr1=1 sr2=2", sr1, sr2);
                end
            end
            @(posedge clock); #1;
            exp = sb.pop_front();
            got = observe();
            last_exp = exp;
            tests_run++;
            if (got !== exp) begin
                tests_failed++;
                $display("FAIL alu_case%0d got=%h exp=%h", i, got, exp);
            end
        end
    endtask

    task automatic test_address();
        res_t exp, got;
        res_t cases[5];
        logic [15:0] irs[5];
        logic [5:0]  ecs[5];
        logic [15:0] npcs[5];
        logic [15:0] v1s[5];
        logic [15:0] v2s[5];
        irs  = '{16'h0405, 16'h05FF, 16'hC1C0, 16'h3A02, 16'h6A43};
        ecs  = '{6'b000110, 6'b000110, 6'b001100, 6'b000110, 6'b001000};
        npcs = '{16'h3001, 16'h3001, 16'h5555, 16'h4000, 16'h7777};
        v1s  = '{16'h0000, 16'h0000, 16'h1234, 16'h0000, 16'h1000};
        v2s  = '{16'h0101, 16'h0202, 16'h0303, 16'hBEEF, 16'h0404};
        cases[0] = '{16'h3006, 16'h3006, 3'd0, 3'b010, 16'h0101, 2'b10, 1'b1, 16'h0405};
        cases[1] = '{16'h3000, 16'h3000, 3'd0, 3'b010, 16'h0202, 2'b10, 1'b1, 16'h05FF};
        cases[2] = '{16'h1234, 16'h1234, 3'd0, 3'b111, 16'h0303, 2'b10, 1'b1, 16'hC1C0};
        cases[3] = '{16'h4002, 16'h4002, 3'd0, 3'b000, 16'hBEEF, 2'b10, 1'b1, 16'h3A02};
        cases[4] = '{16'h1003, 16'h1003, 3'd5, 3'b000, 16'h0404, 2'b10, 1'b1, 16'h6A43};
        for (int i = 0; i < 5; i++) begin
            apply(irs[i], ecs[i], npcs[i], v1s[i], v2s[i], 4'b0000, 16'h0, 2'b10, 1'b1, cases[i]);
            if (i == 3) begin
                #1;
                tests_run++;
                if (sr2 !== 3'd5) begin
                    tests_failed++;
                    $display("FAIL st_sr2 got=%0d exp=5", sr2);
                end
            end
            @(posedge clock); #1;
            exp = sb.pop_front();
            got = observe();
            last_exp = exp;
            tests_run++;
            if (got !== exp) begin
                tests_failed++;
                $display("FAIL addr_case%0d got=%h exp=%h", i, got, exp);
            end
        end
    endtask

    task automatic test_bypass();
        res_t exp, got;
        res_t cases[5];
        logic [3:0]  byps[5];
        logic [15:0] v1s[5];
        logic [15:0] v2s[5];
        // byp = {alu_1, mem_1, alu_2, mem_2}
        byps = '{4'b0000, 4'b1100, 4'b0100, 4'b0001, 4'b0011};
        v1s  = '{16'h0005, 16'hFFFF, 16'hFFFF, 16'h0005, 16'h0005};
        v2s  = '{16'h0007, 16'h0001, 16'h0001, 16'hFFFF, 16'hFFFF};
        cases[0] = '{16'h000C, 16'hFE47, 3'd3, 3'd0, 16'h0007, 2'b11, 1'b0, 16'h1642};
        cases[1] = '{16'h000D, 16'hFE4E, 3'd3, 3'd0, 16'h0001, 2'b11, 1'b0, 16'h1642};
        cases[2] = '{16'h0101, 16'hFF42, 3'd3, 3'd0, 16'h0001, 2'b11, 1'b0, 16'h1642};
        cases[3] = '{16'h0105, 16'hFE47, 3'd3, 3'd0, 16'h0100, 2'b11, 1'b0, 16'h1642};
        cases[4] = '{16'h010A, 16'hFE47, 3'd3, 3'd0, 16'h0105, 2'b11, 1'b0, 16'h1642};
        for (int i = 0; i < 5; i++) begin
            apply(16'h1642, 6'b000001, 16'h0, v1s[i], v2s[i], byps[i], 16'h0100, 2'b11, 1'b0, cases[i]);
            @(posedge clock); #1;
            exp = sb.pop_front();
            got = observe();
            last_exp = exp;
            tests_run++;
            if (got !== exp) begin
                tests_failed++;
                $display("FAIL bypass_case%0d got=%h exp=%h", i, got, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        res_t exp, got;
        logic [15:0] a, b, ir_v, off;
        logic [2:0]  d, s1, s2;
        logic [1:0]  wc;
        logic        mc;
        for (int i = 0; i < 10; i++) begin
            a = 16'($urandom); b = 16'($urandom);
            d = 3'($urandom); s1 = 3'($urandom); s2 = 3'($urandom);
            wc = 2'($urandom); mc = 1'($urandom);
            ir_v = {4'b0001, d, s1, 3'b000, s2};
            off = {{5{ir_v[10]}}, ir_v[10:0]};
            exp = '{a + b, a + off, d, 3'd0, b, wc, mc, ir_v};
            apply(ir_v, 6'b000001, 16'h0, a, b, 4'b0000, 16'h0, wc, mc, exp);
            @(posedge clock); #1;
            exp = sb.pop_front();
            got = observe();
            last_exp = exp;
            tests_run++;
            if (got !== exp) begin
                tests_failed++;
                $display("FAIL b2b_%0d got=%h exp=%h", i, got, exp);
            end
        end
    endtask

    task automatic test_hold();
        res_t got;
        logic [15:0] irs[3];
        irs = '{16'h3A02, 16'h1E85, 16'h0E3F};
        enable_execute = 1'b0;
        for (int i = 0; i < 3; i++) begin
            IR = irs[i]; E_control = 6'($urandom); VSR1 = 16'($urandom); VSR2 = 16'($urandom);
            npc_in = 16'($urandom); W_control_in = 2'($urandom); Mem_control_in = 1'($urandom);
            bypass_alu_1 = 1'b1; bypass_mem_2 = 1'b1; Mem_Bypass_Val = 16'($urandom);
            #1;
            tests_run++;
            if (sr1 !== irs[i][8:6] || sr2 !== (i == 0 ? irs[i][11:9] : irs[i][2:0])) begin
                tests_failed++;
                $display("FAIL hold_srcs%0d got sr1=%0d sr2=%0d", i, sr1, sr2);
            end
            @(posedge clock); #1;
            got = observe();
            tests_run++;
            if (got !== last_exp) begin
                tests_failed++;
                $display("FAIL hold_cycle%0d got=%h exp=%h", i, got, last_exp);
            end
        end
        bypass_alu_1 = 1'b0; bypass_mem_2 = 1'b0;
    endtask

    task automatic test_async_reset();
        res_t got;
        @(posedge clock); #3;
        reset = 1'b1;
        #1;
        got = observe();
        tests_run++;
        if (got !== res_t'(0)) begin
            tests_failed++;
            $display("FAIL async_reset got=%h exp=0", got);
        end
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_alu();
        test_address();
        test_bypass();
        test_back_to_back();
        test_hold();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/lc3_execute.md
Name: lc3_execute

Overview:
- Execute stage of the LC3 pipeline. Sits directly downstream of decode and consumes its E_control, npc_out, Mem_control, W_control and IR outputs.
- Each enabled cycle it computes:
  - the ALU result for ADD/AND/NOT;
  - the effective/branch address for memory, LEA, BR and JMP instructions.
- It registers results and forwards control fields to the memaccess and writeback stages.
- Source operands come from the register file, or from two bypass paths: the previous execute result and the memory-stage result.

Parameters:
- DW, 16, datapath width (IR, npc, operands, results).

Ports:
- clock  input  1  stage clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- enable_execute  input  1  1 = capture new instruction this cycle; 0 = hold all registers.
- E_control  input  6  {alu_op[5:4], pcselect1[3:2], pcselect2[1], op2select[0]} from decode.
- IR  input  16  instruction from decode.
- npc_in  input  16  next-PC from decode.
- Mem_control_in  input  1  memory control from decode.
- W_control_in  input  2  writeback control from decode.
- VSR1  input  16  register-file value for sr1.
- VSR2  input  16  register-file value for sr2.
- bypass_alu_1  input  1  operand1 := aluout register.
- bypass_alu_2  input  1  operand2 := aluout register.
- bypass_mem_1  input  1  operand1 := Mem_Bypass_Val.
- bypass_mem_2  input  1  operand2 := Mem_Bypass_Val.
- Mem_Bypass_Val  input  16  memory-stage result.
- sr1  output  3  IR[8:6], combinational.
- sr2  output  3  IR[11:9] for ST/STR/STI (opcode 0011/0111/1011), else IR[2:0]; combinational.
- aluout  output  16  registered ALU result or effective address.
- pcout  output  16  registered address-adder result.
- dr  output  3  registered destination register.
- NZP  output  3  registered branch condition mask.
- M_Data  output  16  registered store data.
- W_control_out  output  2  registered copy of W_control_in.
- Mem_control_out  output  1  registered copy of Mem_control_in.
- IR_Exec  output  16  registered copy of IR.

Behaviour:

Reset:
- reset=1 asynchronously clears every registered output to 0: aluout, pcout, dr, NZP, M_Data, W_control_out, Mem_control_out, IR_Exec.
- Applies at any time, including mid-instruction; the first capture is the first enabled edge after release.

Operand select (combinational):
- op1 = bypass_alu_1 ? aluout : bypass_mem_1 ? Mem_Bypass_Val : VSR1. ALU bypass has priority when both bypass bits are set.
- r2 uses the same priority with bypass_alu_2, bypass_mem_2 and VSR2.
- op2 = op2select ? r2 : sext(IR[4:0]).

ALU (alu_op):
- 00 ADD: op1+op2, modulo 2^16, carry discarded.
- 01 AND: op1 & op2.
- 10 NOT: ~op1.
- 11: result 0.

Address adder:
- base = pcselect2 ? npc_in : op1.
- offset by pcselect1: 00 sext(IR[10:0]); 01 sext(IR[8:0]); 10 sext(IR[5:0]); 11 0.
- addr = base + offset, modulo 2^16.

Capture at each rising edge with enable_execute=1 (latency 1 cycle):
- pcout <= addr.
- aluout <= ALU result when IR[15:12] ∈ {0001 ADD, 0101 AND, 1001 NOT}; otherwise addr.
- dr <= IR[11:9] for ADD, AND, NOT, LD, LDR, LDI, LEA; otherwise 0.
- NZP <= IR[11:9] for BR (0000); 3'b111 for JMP (1100); otherwise 000.
- M_Data <= r2 (post-bypass).
- W_control_out, Mem_control_out, IR_Exec <= their inputs.

Hold:
- With enable_execute=0, all registers hold their values.
- sr1/sr2 keep tracking IR combinationally.
- Bypass with enable low has no effect, because nothing is captured.

No internal state beyond the output registers. Back-to-back enabled cycles sustain one instruction per cycle.

Test Plan:
1. Register ADD: IR=0x1642 (ADD R3,R1,R2), E_control=000001, VSR1=5, VSR2=7, enable=1 -> next edge aluout=0x000C, dr=3, NZP=0; sr1=1 and sr2=2 combinationally.
2. Immediate AND and NOT:
   - IR=0x553F, E_control=010000, VSR1=0xA5A5 -> aluout=0xA5A5, dr=2.
   - IR=0x967F, E_control=100000, VSR1=0x00FF -> aluout=0xFF00.
3. Branch: IR=0x0405 (BRz +5), E_control=000110, npc_in=0x3001 -> pcout=0x3006, NZP=010, dr=0. Repeat with offset 0x1FF -> pcout=0x3000.
4. Store: IR=0x3A02 (ST R5,+2), E_control=000110, npc_in=0x4000, VSR2=0xBEEF -> sr2=5, pcout=aluout=0x4002, M_Data=0xBEEF, dr=0.
5. Bypass priority: after test 1 (aluout=0x000C), ADD with bypass_alu_1=1, bypass_mem_1=1, Mem_Bypass_Val=0x0100, VSR1=0xFFFF, VSR2=1 -> aluout=0x000D. Then bypass_mem_1 only -> aluout=0x0101.
6. Hold and reset:
   - enable_execute=0 for 3 cycles with changing inputs -> all outputs unchanged.
   - Assert reset between clock edges -> all outputs 0 immediately, without waiting for a clock edge.
